// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order pipeline control register chain with load-use/branch/mult-div
// hazard stall generation and a mult/div busy counter with a registered done pulse.
module pipe_ctrl #(
    parameter int WIDTH  = 11,
    parameter int STAGES = 3,
    parameter int MDLAT  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          ctrlD,
    input  logic                      validD,
    input  logic                      regwriteD,
    input  logic                      memtoregD,
    input  logic [4:0]                writeregD,
    input  logic [4:0]                rsD,
    input  logic [4:0]                rtD,
    input  logic                      usesrsD,
    input  logic                      usesrtD,
    input  logic                      branchD,
    input  logic                      mdstartD,
    input  logic                      mdreadD,
    input  logic                      flushE,
    output logic [STAGES*WIDTH-1:0]   ctrl_q,
    output logic [STAGES-1:0]         valid_q,
    output logic [STAGES*5-1:0]       writereg_q,
    output logic                      stall,
    output logic                      mdbusy,
    output logic                      mddone
);
    logic [WIDTH-1:0]  r_ctrl [STAGES];
    logic [4:0]        r_wr   [STAGES];
    logic [STAGES-1:0] r_valid, r_rw, r_mtr;
    logic [5:0]        r_cnt;
    logic              r_done;
    logic              w_m0, w_m1, w_lu, w_br, w_md, w_ld0, w_start;

    // a register-0 source never creates a dependency
    assign w_m0 = r_valid[0] && r_rw[0] &&
                  ((usesrsD && rsD != 5'd0 && rsD == r_wr[0]) ||
                   (usesrtD && rtD != 5'd0 && rtD == r_wr[0]));
    assign w_m1 = r_valid[1] && r_rw[1] &&
                  ((usesrsD && rsD != 5'd0 && rsD == r_wr[1]) ||
                   (usesrtD && rtD != 5'd0 && rtD == r_wr[1]));
    assign w_lu    = w_m0 && r_mtr[0];
    assign w_br    = branchD && (w_m0 || (w_m1 && r_mtr[1]));
    assign w_md    = (mdstartD || mdreadD) && mdbusy;
    assign stall   = validD && (w_lu || w_br || w_md);
    assign w_ld0   = !stall && !flushE;
    assign w_start = validD && mdstartD && w_ld0;
    assign mdbusy  = r_cnt != 6'd0;
    assign mddone  = r_done;
    assign valid_q = r_valid;

    for (genvar g = 0; g < STAGES; g++) begin : g_out
        assign ctrl_q[g*WIDTH +: WIDTH] = r_ctrl[g];
        assign writereg_q[g*5 +: 5]     = r_wr[g];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_ctrl[k] <= '0;
                r_wr[k]   <= '0;
            end
            r_valid <= '0;
            r_rw    <= '0;
            r_mtr   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_ctrl[0]  <= w_ld0 ? ctrlD : '0;
            r_wr[0]    <= w_ld0 ? writeregD : 5'd0;
            r_valid[0] <= w_ld0 && validD;
            r_rw[0]    <= w_ld0 && regwriteD;
            r_mtr[0]   <= w_ld0 && memtoregD;
            for (int k = 1; k < STAGES; k++) begin
                r_ctrl[k]  <= r_ctrl[k-1];
                r_wr[k]    <= r_wr[k-1];
                r_valid[k] <= r_valid[k-1];
                r_rw[k]    <= r_rw[k-1];
                r_mtr[k]   <= r_mtr[k-1];
            end
            r_cnt  <= w_start ? 6'(MDLAT) : r_cnt - {5'd0, mdbusy};
            r_done <= r_cnt == 6'd1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed steps; accepted instructions are queued and matched
// in order as they leave the last stage.
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] ctrlD;
    logic        validD, regwriteD, memtoregD;
    logic [4:0]  writeregD, rsD, rtD;
    logic        usesrsD, usesrtD, branchD, mdstartD, mdreadD, flushE;
    logic [32:0] ctrl_q;
    logic [2:0]  valid_q;
    logic [14:0] writereg_q;
    logic        stall, mdbusy, mddone;
    logic [10:0] sb[$];
    logic [10:0] exp_c;
    int          errs = 0;
    int          n = 0;

    pipe_ctrl dut (
        .clk(clk), .reset(reset), .ctrlD(ctrlD), .validD(validD),
        .regwriteD(regwriteD), .memtoregD(memtoregD), .writeregD(writeregD),
        .rsD(rsD), .rtD(rtD), .usesrsD(usesrsD), .usesrtD(usesrtD),
        .branchD(branchD), .mdstartD(mdstartD), .mdreadD(mdreadD),
        .flushE(flushE), .ctrl_q(ctrl_q), .valid_q(valid_q),
        .writereg_q(writereg_q), .stall(stall), .mdbusy(mdbusy), .mddone(mddone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [10:0] c, input logic v, input logic rw, input logic mtr,
                       input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic br,
                       input logic mds, input logic mdr, input logic fl);
        ctrlD = c; validD = v; regwriteD = rw; memtoregD = mtr; writeregD = wr;
        rsD = rs; rtD = rt; usesrsD = urs; usesrtD = urt; branchD = br;
        mdstartD = mds; mdreadD = mdr; flushE = fl;
    endtask

    task automatic nop();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // check stall, record acceptance, clock, then match the last stage
    task automatic tick(input logic es, input string tag);
        #1;
        chk(tag, {32'd0, stall}, {32'd0, es});
        if (validD && !es && !flushE) sb.push_back(ctrlD);
        @(posedge clk);
        #1;
        if (valid_q[2]) begin
            if (sb.size() == 0) chk("w_unexpected", {22'd0, ctrl_q[32:22]}, 33'h1ffffffff);
            else begin
                exp_c = sb.pop_front();
                chk("w_order", {22'd0, ctrl_q[32:22]}, {22'd0, exp_c});
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        drv(0, 1, 1, 1, 8, 8, 8, 1, 1, 1, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {30'd0, valid_q}, 0);
        chk("rst_ctrl", ctrl_q, 0);
        chk("rst_wr", {18'd0, writereg_q}, 0);
        chk("rst_busy", {32'd0, mdbusy}, 0);
        chk("rst_done", {32'd0, mddone}, 0);
        chk("rst_stall", {32'd0, stall}, 0);
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drv(11'(i), 1, 1, 0, 5'(i + 10), 5'(i + 20), 0, 1, 0, 0, 0, 0, 0);
            tick(0, "straight_stall");
            if (i == 1) begin
                chk("s0_ctrl", {22'd0, ctrl_q[10:0]}, 1);
                chk("s0_wr", {28'd0, writereg_q[4:0]}, 11);
            end
            if (i == 2) chk("s1_ctrl", {22'd0, ctrl_q[21:11]}, 1);
            if (i == 3) chk("s2_ctrl", {22'd0, ctrl_q[32:22]}, 1);
        end
        drv(6, 1, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, "lu_load");
        drv(7, 1, 1, 0, 12, 8, 0, 1, 0, 0, 0, 0, 0);
        tick(1, "lu_stall");
        chk("lu_bubble", {32'd0, valid_q[0]}, 0);
        tick(0, "lu_release");
        chk("lu_enter", {22'd0, ctrl_q[10:0]}, 7);
        drv(8, 1, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, "br_alu_prod");
        drv(9, 1, 0, 0, 0, 9, 0, 1, 0, 1, 0, 0, 0);
        tick(1, "br_alu_stall");
        tick(0, "br_alu_release");
        drv(10, 1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, "br_ld_prod");
        drv(11, 1, 0, 0, 0, 0, 9, 0, 1, 1, 0, 0, 0);
        tick(1, "br_ld_stall1");
        tick(1, "br_ld_stall2");
        tick(0, "br_ld_release");
        drv(12, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, "br_r0_prod");
        drv(13, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        tick(0, "br_r0_nostall");
        drv(14, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick(0, "md_start");
        drv(15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            chk("md_busy", {32'd0, mdbusy}, 1);
            chk("md_nodone", {32'd0, mddone}, 0);
            tick(1, "md_read_stall");
        end
        chk("md_busy_end", {32'd0, mdbusy}, 0);
        chk("md_done", {32'd0, mddone}, 1);
        tick(0, "md_read_ok");
        chk("md_done_pulse", {32'd0, mddone}, 0);
        drv(16, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick(0, "md2_start");
        nop();
        tick(0, "md2_wait1");
        flushE = 1'b1;
        tick(0, "md2_flush");
        nop();
        tick(0, "md2_wait3");
        chk("md2_busy_flush", {32'd0, mdbusy}, 1);
        drv(17, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick(1, "md_cnt1_stall");
        chk("md2_done", {32'd0, mddone}, 1);
        tick(0, "md_cnt1_accept");
        chk("md3_busy", {32'd0, mdbusy}, 1);
        chk("md3_nodone", {32'd0, mddone}, 0);
        nop();
        repeat (5) tick(0, "md3_wait");
        drv(18, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        tick(0, "md_flush_start");
        chk("md_flush_nobusy", {32'd0, mdbusy}, 0);
        chk("md_flush_bubble", {32'd0, valid_q[0]}, 0);
        drv(19, 1, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, "fs_load");
        drv(20, 1, 0, 0, 0, 8, 0, 1, 0, 0, 0, 0, 1);
        tick(1, "fs_stall");
        chk("fs_bubble", {32'd0, valid_q[0]}, 0);
        chk("fs_load_s1", {22'd0, ctrl_q[21:11]}, 19);
        flushE = 1'b0;
        tick(0, "fs_release");
        chk("fs_enter", {22'd0, ctrl_q[10:0]}, 20);
        drv(21, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick(0, "rm_start");
        drv(22, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, "rm_i22");
        drv(23, 1, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, "rm_i23");
        chk("rm_all_valid", {30'd0, valid_q}, 7);
        chk("rm_busy", {32'd0, mdbusy}, 1);
        reset = 1'b0;
        nop();
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rm_valid", {30'd0, valid_q}, 0);
            chk("rm_nobusy", {32'd0, mdbusy}, 0);
            chk("rm_nodone", {32'd0, mddone}, 0);
        end
        reset = 1'b1;
        repeat (4) tick(0, "drain");
        chk("sb_empty", 33'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errs, n);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter WIDTH, default 11: width of the control bundle carried down the pipeline.
REQ-002 Parameter STAGES, default 3: number of registered stages after decode (stage 0 = E, 1 = M, 2 = W, ...); legal range 2..8.
REQ-003 Parameter MDLAT, default 4: multiply/divide latency in cycles; legal range 1..32.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 ctrlD  in  WIDTH  decoded control bundle for the instruction in D.
REQ-007 validD  in  1  D holds a real instruction.
REQ-008 regwriteD, memtoregD  in  1 each  D instruction writes a register / is a load.
REQ-009 writeregD, rsD, rtD  in  5 each  destination and source register numbers in D.
REQ-010 usesrsD, usesrtD, branchD  in  1 each  D reads rs / reads rt / is a branch resolved in D.
REQ-011 mdstartD, mdreadD  in  1 each  D starts a mult/div / reads hi/lo.
REQ-012 flushE  in  1  force a bubble into E this cycle.
REQ-013 ctrl_q  out  STAGES*WIDTH  flattened per-stage bundles; stage k occupies bits [k*WIDTH +: WIDTH].
REQ-014 valid_q  out  STAGES  per-stage valid bits.
REQ-015 writereg_q  out  STAGES*5  per-stage destination register numbers.
REQ-016 stall  out  1  combinational; hold F and D this cycle.
REQ-017 mdbusy  out  1  mult/div unit is in progress.
REQ-018 mddone  out  1  one-cycle pulse; write hi/lo this cycle (hien/loen).

Function
REQ-019 Stages 1..STAGES-1 SHALL advance unconditionally each cycle: stage k takes stage k-1's bundle, valid, regwrite, memtoreg and writereg.
REQ-020 Stage 0 SHALL load {ctrlD, validD, regwriteD, memtoregD, writeregD} when neither stall nor flushE is asserted; otherwise it SHALL load a bubble: all-zero bundle, valid 0, regwrite 0, memtoreg 0, writereg 0.
REQ-021 Register match SHALL require a nonzero source number, the matching use bit, and the relevant stage valid with regwrite = 1.
REQ-022 Load-use hazard: stall SHALL assert when stage 0 holds a load whose writereg matches rsD or rtD.
REQ-023 Branch hazard: stall SHALL assert when branchD = 1 and either stage 0 (any regwrite) or stage 1 (load only) matches rsD or rtD.
REQ-024 Mult/div hazard: stall SHALL assert when validD = 1 and (mdstartD or mdreadD) while mdbusy = 1.
REQ-025 The stall output SHALL be the OR of REQ-022..024, gated by validD, and SHALL NOT depend on flushE.
REQ-026 The mult/div counter SHALL load MDLAT when validD = 1, mdstartD = 1 and stall = 0 (accepted start).
REQ-027 Otherwise, a nonzero counter SHALL decrement by 1 per cycle.
REQ-028 mdbusy SHALL equal (counter != 0).
REQ-029 mddone SHALL be registered and SHALL pulse high for exactly one cycle, the cycle after the counter transitions from 1 to 0.
REQ-030 A start in D while the counter equals 1 SHALL stall that cycle and SHALL be accepted the next cycle, in the same cycle mddone pulses.
REQ-031 flushE together with stall SHALL produce a single bubble in stage 0; D SHALL stay held by stall.
REQ-032 flushE SHALL NOT cancel an in-progress mult/div.
REQ-033 A start suppressed by flushE SHALL NOT load the counter.

Reset
REQ-034 While reset = 0 at a rising edge, all stages SHALL clear to bubbles: ctrl_q, valid_q and writereg_q all 0.
REQ-035 While reset = 0 at a rising edge, the counter SHALL clear to 0 and mddone to 0, aborting any in-progress mult/div without a mddone pulse.
REQ-036 After reset, stall SHALL be 0 for any D inputs except mult/div inputs, since all stages are empty.

Verification
REQ-037 Straight-line: 5 valid independent instructions with ctrlD = 1..5 -> ctrlD = 1 appears in stage 0 at cycle +1, stage 1 at +2, stage 2 at +3; stall never asserts.
REQ-038 Load-use: load to r8 in stage 0, D reads rs = 8 -> stall = 1 for one cycle; bubble in stage 0; the dependent instruction enters stage 0 on the following cycle with stall = 0.
REQ-039 Branch: branchD reading r9, with an ALU write to r9 in stage 0 -> 1 stall cycle; with a load to r9 in stage 0 -> 2 stall cycles; rs = 0 matches -> no stall.
REQ-040 Mult/div (MDLAT = 4): start at cycle t, mdreadD at t+1 -> mdbusy t+1..t+4; stall t+1..t+4; mddone at t+5; read accepted at t+5.
REQ-041 Flush/stall overlap: flushE with a load-use stall -> single bubble in stage 0; D held; no duplicate or lost instruction afterwards.
REQ-042 Reset mid-operation: reset = 0 while counter = 2 and all stages valid -> next cycle all valid_q = 0, mdbusy = 0, no mddone pulse.
